// File: rtl/mux4_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter_if
// Bundles the request/grant signals shared between four requesters and the
// round-robin arbiter that drives a 4:1 mux select.
//   iReq      [3:0]  request vector, bit k = requester k (requester side drives)
//   oGnt      [3:0]  one-hot grant, all-zero when no owner (arbiter drives)
//   oSel      [1:0]  mux select = index of current or last owner
//   oBusy            high while a grant is active
//   oTimeout         one-cycle pulse after a forced preemption
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mux4_rr_arbiter_if;
  logic [3:0] iReq;
  logic [3:0] oGnt;
  logic [1:0] oSel;
  logic       oBusy;
  logic       oTimeout;

  modport master (
    output iReq,
    input  oGnt, oSel, oBusy, oTimeout
  );

  modport slave (
    input  iReq,
    output oGnt, oSel, oBusy, oTimeout
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter that shares one 4:1 mux between four requesters. One
// owner at a time; tenure is bounded by a hold counter only while someone else
// is waiting. Every ownership change passes through one IDLE cycle with no
// grant (break-before-make).
// Ports:
//   iClk    rising-edge clock
//   iRst_n  asynchronous active-low reset
//   bus     mux4_rr_arbiter_if.slave (iReq in; oGnt/oSel/oBusy/oTimeout out)
// Parameters:
//   MAX_HOLD  max consecutive grant cycles while another requester pends (1..255)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  mux4_rr_arbiter_if.slave     bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           state, stateNext;
  logic [1:0]       ptr, ptrNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [3:0]       gntNext;
  logic [1:0]       selNext;
  logic             busyNext;
  logic             timeoutNext;

  logic [1:0]       idx;
  logic [1:0]       winner;
  logic             found;
  logic [3:0]       ownerMask;
  logic             releaseHit;
  logic             preemptHit;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values computed before the edge.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      bus.oGnt     <= '0;
      bus.oSel     <= '0;
      bus.oBusy    <= 1'b0;
      bus.oTimeout <= 1'b0;
    end else begin
      state        <= stateNext;
      ptr          <= ptrNext;
      cnt          <= cntNext;
      bus.oGnt     <= gntNext;
      bus.oSel     <= selNext;
      bus.oBusy    <= busyNext;
      bus.oTimeout <= timeoutNext;
    end
  end

  // Rotating-priority search: ptr, ptr+1, ptr+2, ptr+3 (mod 4), first hit wins.
  always_comb begin
    idx    = ptr;
    winner = ptr;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && bus.iReq[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // In GRANT the owner is always oSel, since oSel only moves on GRANT entry.
  always_comb begin
    ownerMask  = 4'b0001 << bus.oSel;
    releaseHit = !bus.iReq[bus.oSel];
    preemptHit = (cnt == HOLD_MAX) && (|(bus.iReq & ~ownerMask));
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    stateNext   = state;
    ptrNext     = ptr;
    cntNext     = cnt;
    gntNext     = bus.oGnt;
    selNext     = bus.oSel;
    busyNext    = bus.oBusy;
    timeoutNext = 1'b0;

    unique case (state)
      IDLE: begin
        if (found) begin
          stateNext = GRANT;
          gntNext   = 4'b0001 << winner;
          selNext   = winner;
          busyNext  = 1'b1;
          cntNext   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (releaseHit || preemptHit) begin
          stateNext   = IDLE;
          gntNext     = '0;
          busyNext    = 1'b0;
          ptrNext     = bus.oSel + 2'd1;
          cntNext     = '0;
          // A simultaneous release wins over preemption: no timeout pulse.
          timeoutNext = !releaseHit;
        end else if (cnt != HOLD_MAX) begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Directed and randomized stimulus for mux4_rr_arbiter, checked every cycle
// against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic iClk;
  logic iRst_n;

  mux4_rr_arbiter_if arbIf ();

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (arbIf.slave)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int testsRun = 0;
  int failCnt  = 0;

  // Behavioural model: owner index (-1 = nobody), cycles held so far,
  // next-priority index, last selected index, timeout pulse.
  int   mOwner   = -1;
  int   mTenure  = 0;
  int   mPtr     = 0;
  int   mSel     = 0;
  logic mTimeout = 1'b0;

  task automatic modelReset();
    mOwner   = -1;
    mTenure  = 0;
    mPtr     = 0;
    mSel     = 0;
    mTimeout = 1'b0;
  endtask

  task automatic modelEdge(input logic [3:0] req);
    mTimeout = 1'b0;
    if (mOwner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (mOwner < 0 && req[(mPtr + k) % 4]) begin
          mOwner  = (mPtr + k) % 4;
          mSel    = mOwner;
          mTenure = 1;
        end
      end
    end else if (!req[mOwner]) begin
      mPtr   = (mOwner + 1) % 4;
      mOwner = -1;
    end else if (mTenure >= MAX_HOLD && (req & ~(4'b0001 << mOwner)) != 4'b0000) begin
      mPtr     = (mOwner + 1) % 4;
      mOwner   = -1;
      mTimeout = 1'b1;
    end else begin
      mTenure++;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    testsRun++;
    assert (got === exp)
    else begin
      failCnt++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [3:0] expGnt;
    expGnt = (mOwner < 0) ? 4'b0000 : 4'(4'b0001 << mOwner);
    check({tag, ".gnt"},     arbIf.oGnt,            expGnt);
    check({tag, ".sel"},     {2'b00, arbIf.oSel},   4'(mSel));
    check({tag, ".busy"},    {3'b000, arbIf.oBusy}, {3'b000, (mOwner >= 0)});
    check({tag, ".timeout"}, {3'b000, arbIf.oTimeout}, {3'b000, mTimeout});
  endtask

  // Called at a falling edge: drive, let the rising edge sample, check at the
  // next falling edge.
  task automatic stepCycle(input logic [3:0] req, input string tag);
    arbIf.iReq = req;
    @(posedge iClk);
    if (iRst_n) modelEdge(req);
    @(negedge iClk);
    checkAll(tag);
  endtask

  task automatic doReset();
    iRst_n     = 1'b0;
    arbIf.iReq = 4'b0000;
    modelReset();
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  logic [3:0] rndReq;
  int         timeoutSeen;

  initial begin
    iRst_n     = 1'b0;
    arbIf.iReq = 4'b0000;
    modelReset();
    @(negedge iClk);

    // 1. Reset held: requests ignored, outputs stay zero.
    stepCycle(4'b1111, "rst_hold_a");
    stepCycle(4'b0101, "rst_hold_b");
    stepCycle(4'b1010, "rst_hold_c");
    iRst_n = 1'b1;

    // Grant to 2, then asynchronous reset mid-grant.
    stepCycle(4'b0100, "pre_async");
    stepCycle(4'b0100, "pre_async2");
    check("async.gnt_before", arbIf.oGnt, 4'b0100);
    #2 iRst_n = 1'b0;
    modelReset();
    #1 checkAll("async_rst");
    check("async.gnt_zero", arbIf.oGnt, 4'b0000);
    @(negedge iClk);
    iRst_n = 1'b1;

    // 2. Single requester 2 for 5 cycles, then release; oSel stays 2.
    for (int i = 0; i < 5; i++) stepCycle(4'b0100, "req2");
    stepCycle(4'b0000, "req2_rel");
    check("req2.sel_hold", {2'b00, arbIf.oSel}, 4'd2);
    stepCycle(4'b0000, "idle_hold");
    // ptr is now 3: full request set must pick 3 first.
    stepCycle(4'b1111, "ptr3");
    check("ptr3.gnt", arbIf.oGnt, 4'b1000);
    stepCycle(4'b0000, "ptr3_rel");

    // 3. All requesting for 40 cycles: forced rotation with timeout pulses.
    doReset();
    timeoutSeen = 0;
    for (int i = 0; i < 40; i++) begin
      stepCycle(4'b1111, "rotate");
      if (arbIf.oTimeout) timeoutSeen++;
    end
    testsRun++;
    assert (timeoutSeen == 4)
    else begin
      failCnt++;
      $error("FAIL rotate.timeouts: got %0d expected 4", timeoutSeen);
    end
    stepCycle(4'b0000, "rotate_end");
    stepCycle(4'b0000, "rotate_end2");

    // 4. Lone owner keeps the grant; a newcomer then forces an immediate
    //    preemption because the hold count has saturated.
    doReset();
    for (int i = 0; i < 20; i++) stepCycle(4'b0001, "lone");
    check("lone.gnt", arbIf.oGnt, 4'b0001);
    stepCycle(4'b0011, "lone_preempt");
    check("lone_preempt.timeout", {3'b000, arbIf.oTimeout}, 4'b0001);
    stepCycle(4'b0011, "lone_next");
    stepCycle(4'b0000, "lone_end");
    stepCycle(4'b0000, "lone_end2");

    // 5. Owner 1 releases (ptr=2), then 0011 -> grant 0; 0 releases -> grant 1.
    doReset();
    stepCycle(4'b0010, "o1");
    stepCycle(4'b0010, "o1b");
    stepCycle(4'b0000, "o1_rel");
    stepCycle(4'b0011, "wrap");
    check("wrap.sel", {2'b00, arbIf.oSel}, 4'd0);
    stepCycle(4'b0011, "wrap_b");
    stepCycle(4'b0010, "o0_rel");
    stepCycle(4'b0010, "o1_again");
    check("o1_again.gnt", arbIf.oGnt, 4'b0010);
    stepCycle(4'b0000, "o1_again_rel");

    // 6. Release and preempt at the same edge: plain release, no timeout.
    doReset();
    stepCycle(4'b0001, "tie_start");
    for (int i = 0; i < 7; i++) stepCycle(4'b0011, "tie_hold");
    stepCycle(4'b0010, "tie_rel");
    check("tie.timeout", {3'b000, arbIf.oTimeout}, 4'b0000);
    stepCycle(4'b0010, "tie_next");
    stepCycle(4'b0000, "tie_end");

    // Randomized sticky requests: each bit flips with probability 1/6.
    doReset();
    rndReq = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(5) == 0) rndReq[b] = ~rndReq[b];
      end
      stepCycle(rndReq, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end

endmodule
